// File: rtl/cci_mpf_csr_event_counters_pkg.sv
// Shared constants and the fixed event-to-index map for the MPF CSR event counters.
package cci_mpf_csr_event_counters_pkg;

    localparam int unsigned CCI_MPF_CSR_N_EVENTS      = 13;
    localparam int unsigned CCI_MPF_CSR_EVT_CNT_WIDTH = 48;
    localparam int unsigned CCI_MPF_CSR_RSP_WIDTH     = 64;

    typedef enum logic [3:0] {
        EVT_VTP_4KB_HIT        = 4'd0,
        EVT_VTP_4KB_MISS       = 4'd1,
        EVT_VTP_2MB_HIT        = 4'd2,
        EVT_VTP_2MB_MISS       = 4'd3,
        EVT_PT_WALK_BUSY       = 4'd4,
        EVT_FAILED_TRANSLATION = 4'd5,
        EVT_VC_MAP_CHANGED     = 4'd6,
        EVT_WRO_RR             = 4'd7,
        EVT_WRO_RW             = 4'd8,
        EVT_WRO_WR             = 4'd9,
        EVT_WRO_WW             = 4'd10,
        EVT_PWRITE             = 4'd11,
        EVT_RESERVED           = 4'd12
    } t_cci_mpf_csr_event_idx;

endpackage

// File: rtl/cci_mpf_csr_event_counters_if.sv
// Event pulses, counter read port and clear controls between the shims/CSR manager and the counters.
interface cci_mpf_csr_event_counters_if #(
    parameter int unsigned N_EVENTS  = 13,
    parameter int unsigned IDX_WIDTH = 4
);
    logic [N_EVENTS-1:0]  evt_in;
    logic                 rd_req;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic                 rd_rsp_valid;
    logic [63:0]          rd_rsp_data;
    logic                 clr_req;
    logic [IDX_WIDTH-1:0] clr_idx;
    logic                 clr_all;

    modport master (
        output evt_in, rd_req, rd_idx, clr_req, clr_idx, clr_all,
        input  rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  evt_in, rd_req, rd_idx, clr_req, clr_idx, clr_all,
        output rd_rsp_valid, rd_rsp_data
    );
endinterface

// File: rtl/cci_mpf_prim_event_counter.sv
// Single free-running event counter with a sticky wrap flag; a clear keeps a coincident event.
module cci_mpf_prim_event_counter #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_incr,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_ovf
);
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= WIDTH'(i_incr);
            r_ovf <= 1'b0;
        end else if (i_incr) begin
            r_cnt <= r_cnt + WIDTH'(1);
            if (&r_cnt) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/cci_mpf_csr_event_counters.sv
// Registers per-shim event pulses, counts them per event and serves fixed-latency indexed reads.
module cci_mpf_csr_event_counters
    import cci_mpf_csr_event_counters_pkg::*;
#(
    parameter int unsigned N_EVENTS      = CCI_MPF_CSR_N_EVENTS,
    parameter int unsigned COUNTER_WIDTH = CCI_MPF_CSR_EVT_CNT_WIDTH,
    parameter int unsigned IDX_WIDTH     = $clog2(N_EVENTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    cci_mpf_csr_event_counters_if.slave  ev
);
    logic [N_EVENTS-1:0]      r_evt_q;
    logic [N_EVENTS-1:0]      w_clr;
    logic [N_EVENTS-1:0]      w_ovf;
    logic [COUNTER_WIDTH-1:0] w_cnt [N_EVENTS];

    logic                             r_rd_rsp_valid;
    logic [CCI_MPF_CSR_RSP_WIDTH-1:0] r_rd_rsp_data;
    logic [CCI_MPF_CSR_RSP_WIDTH-1:0] w_rd_data;

    // Retiming stage for events arriving from distant shims.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt_q <= '0;
        end else begin
            r_evt_q <= ev.evt_in;
        end
    end

    for (genvar gi = 0; gi < N_EVENTS; gi++) begin : g_cnt
        assign w_clr[gi] = ev.clr_all | (ev.clr_req & (ev.clr_idx == IDX_WIDTH'(gi)));

        cci_mpf_prim_event_counter #(
            .WIDTH (COUNTER_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .i_incr (r_evt_q[gi]),
            .i_clr  (w_clr[gi]),
            .o_cnt  (w_cnt[gi]),
            .o_ovf  (w_ovf[gi])
        );
    end

    // Out-of-range indices read as zero.
    always_comb begin
        w_rd_data = '0;
        if (32'(ev.rd_idx) < N_EVENTS) begin
            w_rd_data[CCI_MPF_CSR_RSP_WIDTH-1] = w_ovf[ev.rd_idx];
            w_rd_data[COUNTER_WIDTH-1:0]       = w_cnt[ev.rd_idx];
        end
    end

    // Response captures pre-update counter state; data holds between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_rsp_valid <= 1'b0;
            r_rd_rsp_data  <= '0;
        end else begin
            r_rd_rsp_valid <= ev.rd_req;
            if (ev.rd_req) begin
                r_rd_rsp_data <= w_rd_data;
            end
        end
    end

    assign ev.rd_rsp_valid = r_rd_rsp_valid;
    assign ev.rd_rsp_data  = r_rd_rsp_data;
endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Directed bench: a 48-bit counter instance for general behaviour and an 8-bit one for wrap.
module tb_cci_mpf_csr_event_counters;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cci_mpf_csr_event_counters_if #(.N_EVENTS(13), .IDX_WIDTH(4)) if0 ();
    cci_mpf_csr_event_counters_if #(.N_EVENTS(13), .IDX_WIDTH(4)) if1 ();

    cci_mpf_csr_event_counters #(
        .N_EVENTS(13), .COUNTER_WIDTH(48), .IDX_WIDTH(4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .ev    (if0)
    );

    cci_mpf_csr_event_counters #(
        .N_EVENTS(13), .COUNTER_WIDTH(8), .IDX_WIDTH(4)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .ev    (if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one read this cycle and check the response one cycle later.
    task automatic rd(input bit sel, input logic [3:0] idx, input logic [63:0] exp, input string tag);
        if (sel) begin
            if1.rd_req = 1'b1;
            if1.rd_idx = idx;
        end else begin
            if0.rd_req = 1'b1;
            if0.rd_idx = idx;
        end
        tick();
        if (sel) begin
            chk({tag, "_valid"}, 64'(if1.rd_rsp_valid), 64'd1);
            chk({tag, "_data"}, if1.rd_rsp_data, exp);
            if1.rd_req = 1'b0;
        end else begin
            chk({tag, "_valid"}, 64'(if0.rd_rsp_valid), 64'd1);
            chk({tag, "_data"}, if0.rd_rsp_data, exp);
            if0.rd_req = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        if0.evt_in = '0; if0.rd_req = 1'b0; if0.rd_idx = '0;
        if0.clr_req = 1'b0; if0.clr_idx = '0; if0.clr_all = 1'b0;
        if1.evt_in = '0; if1.rd_req = 1'b0; if1.rd_idx = '0;
        if1.clr_req = 1'b0; if1.clr_idx = '0; if1.clr_all = 1'b0;
        tick();
        tick();
        chk("reset_valid0", 64'(if0.rd_rsp_valid), 64'd0);
        chk("reset_data0", if0.rd_rsp_data, 64'd0);
        chk("reset_valid1", 64'(if1.rd_rsp_valid), 64'd0);
        chk("reset_data1", if1.rd_rsp_data, 64'd0);
        reset = 1'b0;

        // Back-to-back reads of every counter after reset.
        for (int i = 0; i < 13; i++) rd(1'b0, 4'(i), 64'd0, "init_rd");

        // Five pulses on event 1: read one cycle after last pulse sees 4, next sees 5.
        if0.evt_in = 13'h0002;
        repeat (5) tick();
        if0.evt_in = '0;
        rd(1'b0, 4'd1, 64'd4, "evt1_early");
        rd(1'b0, 4'd1, 64'd5, "evt1_late");

        // All events pulse once; clr_all coincides with them in evt_q, so each counter is 1.
        if0.evt_in = '1;
        tick();
        if0.evt_in = '0;
        if0.clr_all = 1'b1;
        tick();
        if0.clr_all = 1'b0;
        for (int i = 0; i < 13; i++) rd(1'b0, 4'(i), 64'd1, "clrall_evt");
        if0.clr_all = 1'b1;
        tick();
        if0.clr_all = 1'b0;
        for (int i = 0; i < 13; i++) rd(1'b0, 4'(i), 64'd0, "clrall");

        // Counter 12 = 7, read and clear in the same cycle.
        if0.evt_in = 13'h1000;
        repeat (7) tick();
        if0.evt_in = '0;
        tick();
        if0.clr_req = 1'b1;
        if0.clr_idx = 4'd12;
        rd(1'b0, 4'd12, 64'd7, "rdclr_same");
        if0.clr_req = 1'b0;
        rd(1'b0, 4'd12, 64'd0, "rdclr_after");

        // Out-of-range clear ignored; idle cycle holds data; out-of-range read returns 0.
        if0.evt_in = 13'h0001;
        repeat (2) tick();
        if0.evt_in = '0;
        tick();
        if0.clr_req = 1'b1;
        if0.clr_idx = 4'd13;
        tick();
        if0.clr_req = 1'b0;
        rd(1'b0, 4'd0, 64'd2, "clr_oob");
        tick();
        chk("idle_valid", 64'(if0.rd_rsp_valid), 64'd0);
        chk("idle_hold", if0.rd_rsp_data, 64'd2);
        rd(1'b0, 4'd13, 64'd0, "rd_oob");

        // 8-bit counter: 255 pulses, then wrap sets the sticky flag.
        if1.evt_in = 13'h0008;
        repeat (255) tick();
        if1.evt_in = '0;
        tick();
        rd(1'b1, 4'd3, 64'h0000_0000_0000_00FF, "w8_255");
        if1.evt_in = 13'h0008;
        tick();
        if1.evt_in = '0;
        tick();
        rd(1'b1, 4'd3, 64'h8000_0000_0000_0000, "w8_wrap");
        if1.evt_in = 13'h0008;
        tick();
        if1.evt_in = '0;
        tick();
        rd(1'b1, 4'd3, 64'h8000_0000_0000_0001, "w8_sticky");
        if1.clr_req = 1'b1;
        if1.clr_idx = 4'd3;
        tick();
        if1.clr_req = 1'b0;
        rd(1'b1, 4'd3, 64'd0, "w8_clr");

        // Counter 2 = 9, then reset asserted with a read and pending events in flight.
        if0.evt_in = 13'h0004;
        repeat (9) tick();
        if0.evt_in = '0;
        tick();
        rd(1'b0, 4'd2, 64'd9, "pre_rst");
        if0.evt_in = 13'h0004;
        tick();
        reset = 1'b1;
        if0.rd_req = 1'b1;
        if0.rd_idx = 4'd2;
        tick();
        chk("rst_rd_valid", 64'(if0.rd_rsp_valid), 64'd0);
        reset = 1'b0;
        if0.rd_req = 1'b0;
        if0.evt_in = '0;
        tick();
        chk("rst_no_rsp", 64'(if0.rd_rsp_valid), 64'd0);
        tick();
        rd(1'b0, 4'd2, 64'd0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
